mmio_port_bank: RTL
===================

Name: mmio_port_bank

Overview:
- Parametrised memory-mapped I/O bank that generalises the single hard-wired I/O word to NUM_CH channels plus one status/control word.
- Sits between the core's memory-access signals and the data memory:
  - For non-I/O addresses, it passes the write enable through to memory and forwards memory read data.
  - For I/O addresses, it serves reads and writes itself.
- Each channel has a one-word input holding register with a valid/ready capture handshake, and an OUT_DEPTH-entry output FIFO with a valid/ready drain handshake.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, address width.
- NUM_CH, 4, channel count, 1..8; 2*NUM_CH <= DATA_W.
- OUT_DEPTH, 4, output FIFO depth per channel, power of 2, >= 2.
- IO_BASE, 16'h00FC, address of channel 0. Channel k is at IO_BASE+k, so the default maps channel 3 to 255.
- STAT_ADDR, 16'h00FB, address of the status/control word.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- addr  in  ADDR_W  access address (zero-extended immediate/address path).
- mem_write  in  1  core write request.
- mem_read  in  1  core read request; pops channel input when addressed.
- wr_data  in  DATA_W  core write data (Mary data path).
- mem_rdata  in  DATA_W  data-memory read data.
- mem_we_out  out  1  write enable to data memory; 0 for any I/O address.
- rd_data  out  DATA_W  read data to core.
- stall  out  1  core must hold the access; asserted on a write to a full output FIFO.
- in_data  in  NUM_CH*DATA_W  channel input words; channel k occupies bits [k*DATA_W +: DATA_W].
- in_valid  in  NUM_CH  per-channel input valid.
- in_ready  out  NUM_CH  per-channel: input holding register empty.
- out_data  out  NUM_CH*DATA_W  per-channel FIFO head.
- out_valid  out  NUM_CH  per-channel FIFO non-empty.
- out_ready  in  NUM_CH  per-channel consumer accept.

Behaviour:
- Decode (combinational):
  - hit_ch[k] = (addr == IO_BASE+k).
  - hit_stat = (addr == STAT_ADDR).
  - io_hit = any hit.
  - mem_we_out = mem_write & ~io_hit.
- rd_data (combinational):
  - hit_ch[k]: channel k holding register if full, else 0.
  - hit_stat: bits [NUM_CH-1:0] = in_full; bits [2*NUM_CH-1:NUM_CH] = out_full; upper bits 0.
  - Otherwise: mem_rdata.
- Input channel k:
  - in_ready[k] = ~in_full[k]. Forced 0 while reset is low.
  - Capture: on a clock edge with in_valid[k] & in_ready[k], latch the word and set in_full.
  - Pop: on a clock edge with mem_read & hit_ch[k] & in_full[k], clear in_full. The data is visible on rd_data in the same cycle.
  - Pop and new capture cannot coincide, because in_ready is low while full. A capture may occur the cycle after the pop.
  - A read of an empty channel returns 0 and changes no state.
- Output channel k (FIFO):
  - Push: mem_write & hit_ch[k] & ~full. Pushes wr_data at the tail.
  - Stall: stall = mem_write & hit_ch[k] & full (combinational).
    - The push is dropped; the core retries.
    - A pop in the same cycle does not admit the push; full is judged before the pop.
  - Pop: out_valid[k] & out_ready[k] advances the head.
  - Simultaneous push and pop when non-full and non-empty: occupancy unchanged; order preserved.
  - Push into an empty FIFO: out_valid rises the next cycle (one-cycle latency); out_data is the head register/RAM output.
  - Pointers wrap modulo OUT_DEPTH. Count is log2(OUT_DEPTH)+1 bits; full when count == OUT_DEPTH.
- Status write (mem_write & hit_stat):
  - For each set bit in wr_data[NUM_CH-1:0], flush that output FIFO: pointers and count go to 0 at the edge.
  - Flush beats a simultaneous pop.
  - Other bits are ignored. Input registers are unaffected.
- Simultaneous mem_read and mem_write to the same channel: both take effect (input pop, output push). The two are independent.
- Reset (asynchronous assert, synchronous-safe deassert handled upstream):
  - All in_full = 0; all FIFOs empty.
  - out_valid = 0, in_ready = 0 during reset, stall = 0, out_data = 0.
  - mem_we_out and rd_data remain decode-driven.
  - Reset mid-transfer discards all buffered words.

Decomposition:
- Package mmio_pkg holds:
  - default address constants (IO_BASE, STAT_ADDR);
  - status-bit field offsets (STAT_IN_LSB = 0, STAT_OUT_LSB = NUM_CH);
  - a clog2 helper function.
- One sub-module: mmio_out_fifo (DATA_W, DEPTH), instantiated NUM_CH times via generate.
  - Ports: push, data, full, pop, head, empty, flush.
- The input holding register and the decode stay inline.

Test Plan:
- Pass-through: addr=16'h0010, mem_write=1 -> mem_we_out=1. Then mem_read with mem_rdata=16'hBEEF -> rd_data=16'hBEEF. Stall stays 0.
- Input capture/pop:
  - Drive in_valid[2] with 16'h1234. Next cycle in_ready[2]=0, status bit2=1.
  - Read 16'h00FE -> rd_data=16'h1234. Next cycle in_ready[2]=1.
  - A second read of 16'h00FE returns 0.
- Output FIFO order and full:
  - out_ready[0]=0. Write 1,2,3,4 to 16'h00FC -> status bit4=1.
  - A fifth write of 5 -> stall=1, mem_we_out=0, and the FIFO is unchanged.
  - Raise out_ready -> out_data sequence 1,2,3,4, then out_valid=0.
- Concurrent push/pop: FIFO holds 2 words; push and pop on the same edge -> count stays 2, FIFO order preserved.
- Flush: fill channel 1 with 3 words, then write 16'h0002 to 16'h00FB with out_ready[1]=1 -> the next cycle out_valid[1]=0 and no extra word is popped out.
- Async reset mid-traffic: drop reset between clock edges with FIFOs half full -> out_valid=0 and in_ready=0 immediately. After release, status reads 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants and helpers for the memory-mapped I/O port bank.
package mmio_pkg;

  localparam logic [15:0] DEF_IO_BASE   = 16'h00FC;
  localparam logic [15:0] DEF_STAT_ADDR = 16'h00FB;

  // Status word layout: input-full flags at the bottom, output-full flags above them
  localparam int STAT_IN_LSB = 0;

  typedef enum logic [1:0] {
    ACC_MEM,
    ACC_CHAN,
    ACC_STAT
  } acc_kind_e;

  function automatic int stat_out_lsb(input int num_ch);
    return num_ch;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mmio_out_fifo.sv
// Per-channel output FIFO: power-of-two depth, push dropped when full, flush has top priority.
module mmio_out_fifo
  import mmio_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  input  logic              flush
);

  localparam int AW = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push_en;
  logic              pop_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  // Head is forced to zero when empty so out_data reads zero through reset
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/mmio_port_bank.sv
// Memory-mapped I/O bank: NUM_CH input holding registers, NUM_CH output FIFOs and a
// status/control word, sitting between the core's memory port and the data memory.
module mmio_port_bank
  import mmio_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                NUM_CH    = 4,
  parameter int                OUT_DEPTH = 4,
  parameter logic [ADDR_W-1:0] IO_BASE   = ADDR_W'(DEF_IO_BASE),
  parameter logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(DEF_STAT_ADDR)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     mem_write,
  input  logic                     mem_read,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     mem_we_out,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     stall,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready
);

  localparam int STAT_OUT_LSB = stat_out_lsb(NUM_CH);

  logic [NUM_CH-1:0] hit_ch;
  logic              hit_stat;
  logic              io_hit;
  logic [NUM_CH-1:0] in_full;
  logic [DATA_W-1:0] in_reg [NUM_CH];
  logic [NUM_CH-1:0] out_full;
  logic [NUM_CH-1:0] out_empty;
  logic [NUM_CH-1:0] fifo_push;
  logic [NUM_CH-1:0] fifo_flush;
  logic [DATA_W-1:0] chan_word;
  logic [DATA_W-1:0] stat_word;
  acc_kind_e         acc_kind;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      hit_ch[k] = (addr == IO_BASE + ADDR_W'(k));
    end
  end

  assign hit_stat   = (addr == STAT_ADDR);
  assign io_hit     = (|hit_ch) | hit_stat;
  assign mem_we_out = mem_write & ~io_hit;
  assign stall      = mem_write & (|(hit_ch & out_full));

  always_comb begin
    acc_kind  = ACC_MEM;
    chan_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (hit_ch[k]) begin
        acc_kind = ACC_CHAN;
        if (in_full[k]) chan_word = in_reg[k];
      end
    end
    if (hit_stat) acc_kind = ACC_STAT;
  end

  always_comb begin
    stat_word = '0;
    stat_word[STAT_IN_LSB  +: NUM_CH] = in_full;
    stat_word[STAT_OUT_LSB +: NUM_CH] = out_full;
  end

  always_comb begin
    case (acc_kind)
      ACC_CHAN: rd_data = chan_word;
      ACC_STAT: rd_data = stat_word;
      default:  rd_data = mem_rdata;
    endcase
  end

  // Capture and pop never coincide: capture needs the register empty, pop needs it full
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_full <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (in_valid[k] && !in_full[k]) begin
          in_full[k] <= 1'b1;
        end else if (mem_read && hit_ch[k] && in_full[k]) begin
          in_full[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (in_valid[k] && !in_full[k]) in_reg[k] <= in_data[k*DATA_W +: DATA_W];
    end
  end

  assign in_ready   = ~in_full & {NUM_CH{reset}};
  assign fifo_push  = {NUM_CH{mem_write}} & hit_ch;
  assign fifo_flush = {NUM_CH{mem_write & hit_stat}} & wr_data[NUM_CH-1:0];
  assign out_valid  = ~out_empty;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    mmio_out_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (OUT_DEPTH)
    ) u_fifo (
      .clock(clock),
      .reset(reset),
      .push (fifo_push[g]),
      .data (wr_data),
      .full (out_full[g]),
      .pop  (out_ready[g]),
      .head (out_data[g*DATA_W +: DATA_W]),
      .empty(out_empty[g]),
      .flush(fifo_flush[g])
    );
  end

endmodule
